// File: rtl/tx33_pkg.sv
// tx33_pkg: shared types and constants for the 33 MHz burst writer.
// Contents: word_t (32-bit data word), tx_state_e (writer FSM states), SEQ_W (sequence stamp width).
package tx33_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {IDLE, BURST, GAP} tx_state_e;
    localparam int SEQ_W = 8;
endpackage

// File: rtl/tx33_sync_fifo.sv
// tx33_sync_fifo: first-word-fall-through synchronous FIFO of word_t.
// Ports: clk/reset_n (sync, active-low); push/din write side; pop/dout read side (dout shows the head);
//        full/empty/count occupancy. Push is ignored when full and pop is ignored when empty.
module tx33_sync_fifo
    import tx33_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  word_t                    din,
    input  logic                     pop,
    output word_t                    dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    word_t mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic do_push, do_pop;

    // DEPTH is a power of two, so the count MSB alone marks full
    assign full    = count[AW];
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + AW'(1);
            if (do_pop) rp <= rp + AW'(1);
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end
endmodule

// File: rtl/tx33_burst_writer.sv
// tx33_burst_writer: 33 MHz transmit write stage; buffers source words and emits them as gapped bursts.
// Ports: clk_xt33/reset_n (sync, active-low); src_valid/src_data/src_ready source handshake;
//        fifo_afull downstream throttle; wr_33/wdata registered write to the downstream FIFO;
//        burst_done pulses with the last word of a burst; wr_count counts words written (wraps).
// Optional: define TX33_SEQ_STAMP_EN to replace wdata[31:24] with a rolling sequence number.
module tx33_burst_writer
    import tx33_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int BURST_LEN  = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic        clk_xt33,
    input  logic        reset_n,
    input  logic        src_valid,
    input  logic [31:0] src_data,
    output logic        src_ready,
    input  logic        fifo_afull,
    output logic        wr_33,
    output logic [31:0] wdata,
    output logic        burst_done,
    output logic [31:0] wr_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(BURST_LEN + 1);
    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    tx_state_e state, state_n;
    logic [BW-1:0] beat_cnt;
    logic [GW-1:0] gap_cnt;
    logic [AW:0] count;
    logic full, empty, push, pop, last;
    word_t head, out_word;

`ifdef TX33_SEQ_STAMP_EN
    logic [SEQ_W-1:0] seq;
    assign out_word = {seq, head[31-SEQ_W:0]};
`else
    assign out_word = head;
`endif

    assign src_ready = reset_n && (count < (AW+1)'(DEPTH));
    assign push      = src_valid && src_ready && !full;
    assign pop       = (state == BURST) && !empty && !fifo_afull;
    assign last      = pop && (beat_cnt == BW'(BURST_LEN - 1));

    tx33_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk_xt33),
        .reset_n (reset_n),
        .push    (push),
        .din     (src_data),
        .pop     (pop),
        .dout    (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (!empty && !fifo_afull) state_n = BURST;
            BURST:   if (last) state_n = (GAP_CYCLES > 0) ? GAP : IDLE;
            GAP:     if (gap_cnt == GW'(GAP_CYCLES - 1)) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_xt33) begin
        if (!reset_n) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            gap_cnt    <= '0;
            wr_33      <= 1'b0;
            wdata      <= '0;
            burst_done <= 1'b0;
            wr_count   <= '0;
`ifdef TX33_SEQ_STAMP_EN
            seq        <= '0;
`endif
        end else begin
            state      <= state_n;
            // held at zero while IDLE so every burst starts counting from 0
            beat_cnt   <= (state == IDLE) ? '0 : pop ? beat_cnt + BW'(1) : beat_cnt;
            gap_cnt    <= (state == GAP) ? gap_cnt + GW'(1) : '0;
            wr_33      <= pop;
            burst_done <= last;
            wr_count   <= wr_count + 32'(pop);
            if (pop) wdata <= out_word;
`ifdef TX33_SEQ_STAMP_EN
            if (pop) seq <= seq + SEQ_W'(1);
`endif
        end
    end
endmodule

// File: doc/tx33_burst_writer.md
Name: tx33_burst_writer

Overview:
- Transmitter-side write stage in the 33 MHz domain. It feeds the wr_33/wdata pair into the 33→25 MHz bus-transfer data-integrity checker and its async FIFO.
- Accepts 32-bit words from a source over a valid/ready handshake and buffers them in a small internal FIFO.
- Emits them as bounded bursts separated by programmable idle gaps, throttled by the downstream almost-full flag.

Parameters:
DEPTH, 4, internal buffer depth in words; power of 2, minimum 2.
BURST_LEN, 8, words per burst; minimum 1.
GAP_CYCLES, 2, idle clk_xt33 cycles forced between bursts; 0 means no gap.

Ports:
clk_xt33  in  1  transmitter clock, 33 MHz; only clock.
reset_n  in  1  active-low reset, synchronous to clk_xt33.
src_valid  in  1  source word valid.
src_data  in  32  source word.
src_ready  out  1  buffer can accept a word.
fifo_afull  in  1  downstream almost-full, already synchronous to clk_xt33.
wr_33  out  1  registered write strobe to the downstream stage.
wdata  out  32  registered write data; valid only when wr_33=1.
burst_done  out  1  one-cycle pulse, coincident with the last wr_33 of a burst.
wr_count  out  32  total words written since reset.

Behaviour:
- One clock, clk_xt33. reset_n is synchronous and active-low.
- Reset values:
  - wr_33=0, wdata=0, burst_done=0, wr_count=0.
  - src_ready=0 during reset, then 1 from the first cycle after reset.
  - Buffer is emptied and state is IDLE.
- Reset mid-operation discards all buffered words and any partial burst.
- Input handshake:
  - A word is pushed on a rising edge where src_valid && src_ready.
  - src_ready = (count < DEPTH), combinational from the registered count.
  - No push is accepted when full, even if a pop happens in the same cycle.
  - Simultaneous push and pop when not full leaves count unchanged.
- Pop condition: pop = (state==BURST) && !empty && !fifo_afull, sampled at the edge.
- Output registers: on a pop, wr_33<=1 and wdata<=head word on that edge; otherwise wr_33<=0 and wdata holds its value.
- Minimum latency from push edge to wr_33 high is 2 cycles.
- fifo_afull response: a rising fifo_afull stops pops at that edge, so wr_33 drops on the next cycle. The downstream threshold must therefore leave at least 1 free slot.
- FSM states:
  - IDLE → BURST when !empty && !fifo_afull. The beat counter clears on entry.
  - BURST: each pop increments the beat counter. On the pop that reaches BURST_LEN, burst_done<=1 with that word, then:
    - → GAP if GAP_CYCLES>0;
    - → IDLE otherwise.
  - BURST with the buffer empty or fifo_afull high: stall in BURST with no timeout. The burst completes only after BURST_LEN words.
  - GAP: the gap counter runs GAP_CYCLES cycles with no pops, then → IDLE. Pushes continue during GAP.
- Width rules:
  - Buffer pointers are log2(DEPTH) bits and wrap naturally.
  - count is log2(DEPTH)+1 bits.
  - The beat counter is $clog2(BURST_LEN+1) bits.
  - wr_count increments by 1 per wr_33 and wraps modulo 2^32.
- Data order is strict FIFO; no word is dropped or duplicated.

Optional Feature:
TX33_SEQ_STAMP_EN
- Defined: wdata[31:24] is replaced by an 8-bit rolling sequence number (0 after reset, +1 per written word, wraps 255→0). wdata[23:0] carries src_data[23:0]. This lets the downstream integrity checker detect loss or reordering.
- Undefined: wdata carries src_data unmodified and no sequence register exists.

Decomposition:
- Shared package tx33_pkg:
  - typedef word_t (logic [31:0]);
  - typedef enum tx_state_e {IDLE, BURST, GAP};
  - localparam SEQ_W=8.
- One sub-module: tx33_sync_fifo. It is a parameterized synchronous FIFO (DEPTH, word_t) with push/pop/full/empty/count.
- The FSM, output registers and counters stay in tx33_burst_writer.

Test Plan:
1. Reset then 8 words 0x1..0x8 pushed back-to-back, fifo_afull=0.
   - Required: first wr_33 2 cycles after the first push.
   - Required: 8 consecutive wr_33 with wdata 0x1..0x8 in order.
   - Required: burst_done with 0x8, then 2 idle cycles; wr_count=8.
2. Push 20 words continuously, BURST_LEN=8, GAP_CYCLES=2.
   - Required: bursts of 8, 8, 4, with exactly 2-cycle gaps after each full burst.
   - Required: src_ready drops whenever 4 words are buffered.
3. Raise fifo_afull mid-burst after the 3rd write for 5 cycles.
   - Required: at most 1 further wr_33 follows, then none while afull is high.
   - Required: the burst resumes and completes 8 words with no loss; burst_done only on the 8th word.
4. Assert reset_n=0 for 1 cycle with 3 words buffered mid-burst.
   - Required: outputs zeroed next cycle and buffer empty.
   - Required: the next pushed word 0xA5 is the first word out, wr_count=1.
5. Simultaneous push/pop at count=2 for 10 cycles.
   - Required: count stays 2 and output order matches input order.
6. TX33_SEQ_STAMP_EN defined, 300 words written.
   - Required: wdata[31:24] runs 0..255 then wraps to 0..43.
   - Required: wdata[23:0] equals src_data[23:0].
